// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: opcodes, alu_op encodings, immediate kinds and control bundle for rv_decode_unit
package rv_decode_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/rv_regfile.sv
// rv_regfile: 2R/1W register file, x0 hardwired to zero; RV_DECODE_WB_BYPASS_EN forwards same-cycle write-back to reads
module rv_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [XLEN-1:0]   rd1_o,
  output logic [XLEN-1:0]   rd2_o
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic byp1, byp2;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      regs_q[wa_i] <= wd_i;
    end
  end
`ifdef RV_DECODE_WB_BYPASS_EN
  assign byp1 = we_i && wa_i != '0 && wa_i == ra1_i;
  assign byp2 = we_i && wa_i != '0 && wa_i == ra2_i;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign rd1_o = (ra1_i == '0) ? '0 : byp1 ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : byp2 ? wd_i : regs_q[ra2_i];
endmodule

// File: rtl/rv_decode_unit.sv
// rv_decode_unit: RV32I/RV64I decode stage with register file, load-use interlock and flush
// RV_DECODE_WB_BYPASS_EN (in rv_regfile) makes same-cycle write-back visible to operand reads
module rv_decode_unit
  import rv_decode_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   imm,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              alu_src,
  output logic              branch,
  output logic              jump,
  output logic [1:0]        alu_op,
  output logic              illegal
);
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    ctrl_t             ctrl;
  } id_t;
  id_t dec, out_d, out_q;
  ctrl_t ctrl;
  imm_t itype;
  logic [6:0] op;
  logic [REG_AW-1:0] s1, s2;
  logic [XLEN-1:0] rf1, rf2;
  logic signed [31:0] imm32;
  logic uses1, uses2, hazard, load_en, take, clr;
  assign op = if_instr[6:0];
  assign s1 = if_instr[15 +: REG_AW];
  assign s2 = if_instr[20 +: REG_AW];
  rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .reset(reset),
    .we_i(wb_we), .wa_i(wb_rd), .wd_i(wb_data),
    .ra1_i(s1), .ra2_i(s2), .rd1_o(rf1), .rd2_o(rf2)
  );
  always_comb begin
    ctrl = '0;
    itype = IMM_NONE;
    case (op)
      OP_R:      begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_R; end
      OP_IMM:    begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_I; itype = IMM_I; end
      OP_LOAD:   begin ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.alu_src = 1'b1; itype = IMM_I; end
      OP_STORE:  begin ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; itype = IMM_S; end
      OP_BRANCH: begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_BR; itype = IMM_B; end
      OP_JAL:    begin ctrl.jump = 1'b1; ctrl.reg_write = 1'b1; itype = IMM_J; end
      OP_JALR:   begin ctrl.jump = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; itype = IMM_I; end
      OP_LUI,
      OP_AUIPC:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; itype = IMM_U; end
      default:   ctrl.illegal = 1'b1;
    endcase
  end
  assign imm32 = itype == IMM_I ? {{20{if_instr[31]}}, if_instr[31:20]} :
                 itype == IMM_S ? {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]} :
                 itype == IMM_B ? {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0} :
                 itype == IMM_U ? {if_instr[31:12], 12'b0} :
                 itype == IMM_J ? {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0} :
                 '0;
  always_comb begin
    dec = '0;
    dec.valid = 1'b1;
    dec.pc = if_pc;
    dec.rs1_data = rf1;
    dec.rs2_data = rf2;
    dec.imm = XLEN'(imm32);
    dec.rs1 = s1;
    dec.rs2 = s2;
    dec.rd = if_instr[7 +: REG_AW];
    dec.opcode = op;
    dec.funct3 = if_instr[14:12];
    dec.funct7 = if_instr[31:25];
    dec.ctrl = ctrl;
  end
  // source-use check looks at if_instr alone so if_ready never depends on if_valid
  assign uses1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  assign uses2 = op == OP_R || op == OP_STORE || op == OP_BRANCH;
  assign hazard = out_q.valid && out_q.ctrl.mem_read && out_q.rd != '0 &&
                  ((uses1 && s1 == out_q.rd) || (uses2 && s2 == out_q.rd));
  assign load_en = !out_q.valid || ex_ready;
  assign if_ready = flush || (load_en && !hazard);
  assign take = if_valid && if_ready && !flush;
  assign clr = flush || (load_en && !take);
  assign out_d = clr ? '0 : take ? dec : out_q;
  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else out_q <= out_d;
  end
  assign id_valid = out_q.valid;
  assign id_pc = out_q.pc;
  assign rs1_data = out_q.rs1_data;
  assign rs2_data = out_q.rs2_data;
  assign imm = out_q.imm;
  assign rs1 = out_q.rs1;
  assign rs2 = out_q.rs2;
  assign rd = out_q.rd;
  assign opcode = out_q.opcode;
  assign funct3 = out_q.funct3;
  assign funct7 = out_q.funct7;
  assign reg_write = out_q.ctrl.reg_write;
  assign mem_read = out_q.ctrl.mem_read;
  assign mem_write = out_q.ctrl.mem_write;
  assign alu_src = out_q.ctrl.alu_src;
  assign branch = out_q.ctrl.branch;
  assign jump = out_q.ctrl.jump;
  assign alu_op = out_q.ctrl.alu_op;
  assign illegal = out_q.ctrl.illegal;
endmodule

// File: doc/rv_decode_unit.md
# rv_decode_unit

Parametrised RISC-V RV32I/RV64I decode stage with an integrated register file, valid/ready handshakes on both sides, load-use interlock, and flush. It sits between fetch and execute, replacing the single-cycle decode register. It adds:
- full immediate generation (I/S/B/U/J)
- back-pressure from execute
- bubble insertion on load-use hazards
- write-back port into the register file

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64); immediates sign-extended to XLEN
- NREGS, 32, architectural registers (16 for RV32E, else 32); index width REG_AW = $clog2(NREGS)

Ports:
- clk  in  1  clock; everything on rising edge
- reset  in  1  synchronous, active-high
- if_valid  in  1  fetch presents instruction
- if_ready  out  1  decode accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  its PC
- flush  in  1  kill in-flight and incoming instruction (redirect)
- wb_we  in  1  write-back enable
- wb_rd  in  REG_AW  write-back register
- wb_data  in  XLEN  write-back value
- id_valid  out  1  output register holds a real instruction
- ex_ready  in  1  execute accepts
- id_pc  out  XLEN  PC of decoded instruction
- rs1_data, rs2_data  out  XLEN  operand values
- imm  out  XLEN  immediate
- rs1, rs2, rd  out  REG_AW  register indices
- opcode  out  7, funct3  out  3, funct7  out  7  raw fields
- reg_write, mem_read, mem_write, alu_src, branch, jump  out  1  controls
- alu_op  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type arith
- illegal  out  1  opcode not in supported set

## Operation
- Transfer in on if_valid && if_ready; transfer out on id_valid && ex_ready.
- Output register loads when empty or ex_ready; otherwise all outputs hold.
- Decode: opcode 0110011 R, 0010011 I-arith, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC. Any other opcode: illegal=1, all write/mem controls 0, still passed with id_valid=1.
- Immediates:
  - I: instr[31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - All sign-extended to XLEN; R-type imm=0.
- Controls:
  - JAL/JALR: jump=1, reg_write=1.
  - LUI/AUIPC: reg_write=1, alu_src=1, alu_op=00.
  - Others follow the alu_op table above.
- rs1 is used by all except LUI/AUIPC/JAL; rs2 is used by R/S/B only.
- Register file:
  - NREGS×XLEN; x0 reads 0 and ignores writes.
  - Write on wb_we at the clock edge; all entries clear on reset.
- Load-use interlock:
  - hazard = id_valid && mem_read && rd!=0 && incoming instruction uses a source equal to rd.
  - If hazard and ex_ready: output register loads a bubble (id_valid=0, controls 0), and if_ready=0.
  - Next cycle there is no hazard and the held instruction is accepted. Exactly one bubble per load-use.
- if_ready = (!id_valid || ex_ready) && !hazard. if_ready is combinational and does not depend on if_valid.
- Flush (priority over all except reset):
  - Next cycle id_valid=0 and controls are 0.
  - An instruction offered in the flush cycle is dropped; if_ready still reports 1.
  - Write-back still occurs.

## Timing
- Latency: 1 cycle from accepted instruction to id_valid=1.
- Throughput: 1/cycle without stalls.
- Reset values: all outputs 0 (id_valid=0, illegal=0, id_pc=0). if_ready=1 after reset.
- Simultaneous wb_we and read of the same register: see Configuration.
- Reset mid-stall: the held instruction is discarded.

## Configuration
- RV_DECODE_WB_BYPASS_EN defined: when wb_we && wb_rd!=0 && wb_rd==source index, the operand takes wb_data in the same cycle.
- Undefined: the operand takes the pre-write value. The compiler or hazard logic must separate by one cycle.

## Structure
- Package rv_decode_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - alu_op encodings
  - imm-type enum
- Sub-module rv_regfile (2 read / 1 write, x0 hardwired, bypass macro inside).
- Immediate generation and control decode stay in the top as combinational logic feeding the output register.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with ex_ready=1 → next cycle id_valid=1, imm=5, rd=1, reg_write=1, alu_src=1, alu_op=11.
- wb writes x2=0xDEADBEEF, then `add x3,x2,x2` → rs1_data=rs2_data=0xDEADBEEF. Same-cycle write gives the new value only with RV_DECODE_WB_BYPASS_EN.
- `lw x5,0(x1)` then `add x6,x5,x0` → one cycle if_ready=0 with an id_valid=0 bubble, then the add is issued. The same pair with rd=x0 causes no bubble.
- ex_ready=0 for 3 cycles with `sw x2,-4(x1)` held → outputs stable, imm=0xFFFFFFFC, mem_write=1, if_ready=0.
- flush asserted with id_valid=1 and an incoming `jal x1,-8` → next cycle id_valid=0. A jal offered afterwards gives imm=0xFFFFFFF8, jump=1.
- Opcode 0x7F → illegal=1, reg_write=mem_write=0, id_valid=1.
